// File: rtl/control_unit.sv
// SPARC V8 integer-subset decoder: instr -> registered 19-bit control bundle, 1-cycle latency, no backpressure.
// Define CU_ILLEGAL_FLAG_EN to add a registered illegal_instr flag alongside the bundle.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] instr,
  output logic [18:0] instr_signals
`ifdef CU_ILLEGAL_FLAG_EN
  ,
  output logic        illegal_instr
`endif
);

  typedef struct packed {
    logic       jmpl;
    logic       call;
    logic       branch;
    logic       load;
    logic       mem_enable;
    logic       rf_le;
    logic       modify_cc;
    logic [3:0] alu_op;
    logic [2:0] so_sel;
    logic       mem_rw;
    logic [1:0] mem_size;
    logic       mem_se;
    logic       sethi;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] SO_RS2   = 3'b000;
  localparam logic [2:0] SO_SIMM  = 3'b001;
  localparam logic [2:0] SO_IMM22 = 3'b010;
  localparam logic [2:0] SO_DISP22 = 3'b011;
  localparam logic [2:0] SO_DISP30 = 3'b100;
  localparam logic [2:0] SO_SHCNT = 3'b101;

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       i_bit;
  logic [2:0] so_reg_imm;

  assign op         = instr[31:30];
  assign op2        = instr[24:22];
  assign op3        = instr[24:19];
  assign i_bit      = instr[13];
  assign so_reg_imm = i_bit ? SO_SIMM : SO_RS2;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  supported;
  logic  illegal_d;
  logic  illegal_q;

  always_comb begin
    ctrl_d    = '0;
    supported = 1'b0;
    unique case (op)
      2'b01: begin
        supported     = 1'b1;
        ctrl_d.call   = 1'b1;
        ctrl_d.rf_le  = 1'b1;
        ctrl_d.alu_op = ALU_ADD;
        ctrl_d.so_sel = SO_DISP30;
      end
      2'b00: begin
        if (op2 == 3'b100) begin
          supported     = 1'b1;
          ctrl_d.sethi  = 1'b1;
          ctrl_d.rf_le  = 1'b1;
          ctrl_d.alu_op = ALU_PASSB;
          ctrl_d.so_sel = SO_IMM22;
        end else if (op2 == 3'b010) begin
          supported     = 1'b1;
          ctrl_d.branch = 1'b1;
          ctrl_d.so_sel = SO_DISP22;
        end
      end
      2'b10: begin
        // op3[4] only selects the cc-setting variant, so both halves share one decode
        if (!op3[5] && (!op3[3] || op3[2:0] == 3'b000 || op3[2:0] == 3'b100)) begin
          supported        = 1'b1;
          ctrl_d.rf_le     = 1'b1;
          ctrl_d.modify_cc = op3[4];
          ctrl_d.alu_op    = op3[3:0];
          ctrl_d.so_sel    = so_reg_imm;
        end else begin
          unique case (op3)
            6'b100101, 6'b100110, 6'b100111: begin
              supported     = 1'b1;
              ctrl_d.rf_le  = 1'b1;
              ctrl_d.so_sel = i_bit ? SO_SHCNT : SO_RS2;
              unique case (op3[1:0])
                2'b01:   ctrl_d.alu_op = ALU_SLL;
                2'b10:   ctrl_d.alu_op = ALU_SRL;
                default: ctrl_d.alu_op = ALU_SRA;
              endcase
            end
            6'b111000: begin
              supported     = 1'b1;
              ctrl_d.jmpl   = 1'b1;
              ctrl_d.rf_le  = 1'b1;
              ctrl_d.alu_op = ALU_ADD;
              ctrl_d.so_sel = so_reg_imm;
            end
            default: ;
          endcase
        end
      end
      default: begin
        // op3[1:0] maps 00/01/10/11 to word/byte/half/dword for both loads and stores
        if (op3[5:3] == 3'b000 || op3 == 6'b001001 || op3 == 6'b001010) begin
          supported         = 1'b1;
          ctrl_d.mem_enable = 1'b1;
          ctrl_d.alu_op     = ALU_ADD;
          ctrl_d.so_sel     = so_reg_imm;
          unique case (op3[1:0])
            2'b00:   ctrl_d.mem_size = 2'b10;
            2'b01:   ctrl_d.mem_size = 2'b00;
            2'b10:   ctrl_d.mem_size = 2'b01;
            default: ctrl_d.mem_size = 2'b11;
          endcase
          if (op3[2] && !op3[3]) begin
            ctrl_d.mem_rw = 1'b1;
          end else begin
            ctrl_d.load   = 1'b1;
            ctrl_d.rf_le  = 1'b1;
            ctrl_d.mem_se = op3[3];
          end
        end
      end
    endcase
    illegal_d = !supported && (instr != 32'h0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_signals = ctrl_q;

`ifdef CU_ILLEGAL_FLAG_EN
  assign illegal_instr = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a per-mnemonic reference model checked every cycle, plus literal vectors.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] instr = 32'h8A000000;
  logic [18:0] instr_signals;
  logic        illegal_instr;

  int n_cmp  = 0;
  int n_fail = 0;

  control_unit dut (
    .clk          (clk),
    .clr          (clr),
    .instr        (instr),
    .instr_signals(instr_signals)
`ifdef CU_ILLEGAL_FLAG_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

`ifndef CU_ILLEGAL_FLAG_EN
  assign illegal_instr = 1'b0;
`endif

  always #5 clk = ~clk;

  // Returns {illegal, bundle} from a mnemonic-level table.
  function automatic logic [19:0] model(input logic [31:0] w);
    logic       jm, ca, br, ld, me, rf, cc, rw, se, sh, ok;
    logic [3:0] alu;
    logic [2:0] so;
    logic [1:0] sz;
    logic [5:0] o3;
    logic       imm;
    {jm, ca, br, ld, me, rf, cc, rw, se, sh, ok} = '0;
    alu = 0; so = 0; sz = 0;
    o3  = w[24:19];
    imm = w[13];
    if (w[31:30] == 2'd1) begin
      ok = 1; ca = 1; rf = 1; so = 4;
    end else if (w[31:30] == 2'd0) begin
      if (w[24:22] == 3'd4) begin
        ok = 1; sh = 1; rf = 1; alu = 9; so = 2;
      end else if (w[24:22] == 3'd2) begin
        ok = 1; br = 1; so = 3;
      end
    end else if (w[31:30] == 2'd2) begin
      ok = 1; rf = 1; so = imm ? 1 : 0;
      case (o3)
        6'o00: alu = 0;  6'o01: alu = 1;  6'o02: alu = 2;  6'o03: alu = 3;
        6'o04: alu = 4;  6'o05: alu = 5;  6'o06: alu = 6;  6'o07: alu = 7;
        6'o10: alu = 8;  6'o14: alu = 12;
        6'o20: begin alu = 0;  cc = 1; end
        6'o21: begin alu = 1;  cc = 1; end
        6'o22: begin alu = 2;  cc = 1; end
        6'o23: begin alu = 3;  cc = 1; end
        6'o24: begin alu = 4;  cc = 1; end
        6'o25: begin alu = 5;  cc = 1; end
        6'o26: begin alu = 6;  cc = 1; end
        6'o27: begin alu = 7;  cc = 1; end
        6'o30: begin alu = 8;  cc = 1; end
        6'o34: begin alu = 12; cc = 1; end
        6'o45: begin alu = 10; so = imm ? 5 : 0; end
        6'o46: begin alu = 11; so = imm ? 5 : 0; end
        6'o47: begin alu = 13; so = imm ? 5 : 0; end
        6'o70: jm = 1;
        default: begin ok = 0; rf = 0; so = 0; end
      endcase
    end else begin
      ok = 1; me = 1; so = imm ? 1 : 0;
      case (o3)
        6'o00: begin ld = 1; sz = 2; end
        6'o01: begin ld = 1; sz = 0; end
        6'o02: begin ld = 1; sz = 1; end
        6'o03: begin ld = 1; sz = 3; end
        6'o11: begin ld = 1; sz = 0; se = 1; end
        6'o12: begin ld = 1; sz = 1; se = 1; end
        6'o04: begin rw = 1; sz = 2; end
        6'o05: begin rw = 1; sz = 0; end
        6'o06: begin rw = 1; sz = 1; end
        6'o07: begin rw = 1; sz = 3; end
        default: begin ok = 0; me = 0; so = 0; end
      endcase
      rf = ld;
    end
    return {(!ok && w != 0), jm, ca, br, ld, me, rf, cc, alu, so, rw, sz, se, sh};
  endfunction

  function automatic logic [31:0] fmt3(input logic [1:0] op, input logic [5:0] op3,
                                       input logic i, input logic [12:0] low);
    return {op, 5'd5, op3, 5'd1, i, low};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, using the inputs seen at the edge.
  always @(posedge clk) begin
    logic [19:0] e;
    logic [31:0] w;
    w = instr;
    e = clr ? 20'h0 : model(instr);
    #1;
    check($sformatf("stream bundle instr=%h clr=%0b", w, clr), {13'b0, instr_signals}, {13'b0, e[18:0]});
`ifdef CU_ILLEGAL_FLAG_EN
    check($sformatf("stream illegal instr=%h", w), {31'b0, illegal_instr}, {31'b0, e[19]});
`endif
  end

  task automatic apply(input logic [31:0] w, input logic c);
    @(negedge clk);
    instr = w;
    clr   = c;
  endtask

  task automatic apply_chk(input string name, input logic [31:0] w, input logic c,
                           input logic [18:0] exp);
    apply(w, c);
    @(posedge clk);
    #2;
    check(name, {13'b0, instr_signals}, {13'b0, exp});
  endtask

  initial begin
    // reset held for two edges while a valid instruction is presented
    apply_chk("reset edge 1", 32'h8A000000, 1'b1, 19'h00000);
    apply_chk("reset edge 2", 32'h8A000000, 1'b1, 19'h00000);
    apply_chk("instr zero",   32'h00000000, 1'b0, 19'h00000);

    apply_chk("add",   32'h8A000000, 1'b0, 19'h02000);
    apply_chk("subcc", 32'h86A0E001, 1'b0, 19'h03420);
    apply_chk("ldub",  32'hC4080001, 1'b0, 19'h0E000);
    apply_chk("stb",   32'hCA286001, 1'b0, 19'h04030);
    apply_chk("bne",   32'h12BFFFFE, 1'b0, 19'h10060);
    apply_chk("sethi", 32'h0B0F0F06, 1'b0, 19'h02941);
    apply_chk("call",  32'h40000004, 1'b0, 19'h22080);

    // mid-stream clear zeroes one bundle only
    apply_chk("add stream 1", 32'h8A000000, 1'b0, 19'h02000);
    apply_chk("add clr",      32'h8A000000, 1'b1, 19'h00000);
    apply_chk("add resume",   32'h8A000000, 1'b0, 19'h02000);

    apply_chk("unsupported op3 076", 32'h81F00000, 1'b0, 19'h00000);
`ifdef CU_ILLEGAL_FLAG_EN
    check("illegal flag set", {31'b0, illegal_instr}, 32'd1);
    apply_chk("zero after illegal", 32'h00000000, 1'b0, 19'h00000);
    check("illegal flag clear on zero", {31'b0, illegal_instr}, 32'd0);
`endif

    // remaining encodings are checked by the per-cycle model compare
    apply(fmt3(2'b10, 6'o25, 1'b1, 13'h0FFF), 1'b0);
    apply(fmt3(2'b10, 6'o07, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b10, 6'o10, 1'b1, 13'h1000), 1'b0);
    apply(fmt3(2'b10, 6'o34, 1'b0, 13'h0003), 1'b0);
    apply(fmt3(2'b10, 6'o45, 1'b1, 13'h001F), 1'b0);
    apply(fmt3(2'b10, 6'o46, 1'b0, 13'h0004), 1'b0);
    apply(fmt3(2'b10, 6'o47, 1'b1, 13'h0007), 1'b0);
    apply(fmt3(2'b10, 6'o70, 1'b1, 13'h0008), 1'b0);
    apply(fmt3(2'b11, 6'o00, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b11, 6'o12, 1'b1, 13'h0010), 1'b0);
    apply(fmt3(2'b11, 6'o11, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b11, 6'o03, 1'b1, 13'h0008), 1'b0);
    apply(fmt3(2'b11, 6'o06, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b11, 6'o07, 1'b1, 13'h0008), 1'b0);
    apply(fmt3(2'b11, 6'o04, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b10, 6'o15, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b10, 6'o11, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b11, 6'o10, 1'b0, 13'h0002), 1'b0);
    apply(fmt3(2'b11, 6'o13, 1'b0, 13'h0002), 1'b0);
    apply({2'b00, 5'd3, 3'b110, 22'h001234}, 1'b0);
    apply({2'b00, 5'd0, 3'b000, 22'h000001}, 1'b0);
    apply(fmt3(2'b10, 6'o24, 1'b1, 13'h0001), 1'b1);
    apply(fmt3(2'b10, 6'o24, 1'b1, 13'h0001), 1'b0);
    apply(32'h00000000, 1'b0);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
